// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Purpose  : Types and constants shared by the CNN row/window front end:
//             the default pixel width, the pixel type and the window FSM
//             state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

   localparam int PIXEL_W_DEF = 8;

   typedef logic [PIXEL_W_DEF-1:0] pixel_t;

   // FILL: collecting rows of a new stripe, no complete window yet.
   // SLIDE: every further accepted row yields a new window one row lower.
   typedef enum logic [0:0] {
      FILL  = 1'b0,
      SLIDE = 1'b1
   } win_state_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/row_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : row_window_ctrl
//  Purpose  : Control half of row_window_buf. Decides when a row slice is
//             popped from upstream, counts rows within the current stripe,
//             tracks how many rows of the window are filled and raises the
//             window-valid flag and the end-of-stripe pulse.
//  Ports    : clock, reset (async, active-low)
//             row_shift_rdy_i - upstream has a full slice
//             win_ready_i     - downstream consumes the window
//             accept_o        - pop/capture strobe (combinational)
//             win_valid_o     - window register holds a complete window
//             stripe_done_o   - one-cycle pulse after a stripe's last row
//  Revision : 1.0  initial release
// ============================================================================
module row_window_ctrl
   import cnn_pkg::*;
#(
   parameter int KERNEL     = 3,
   parameter int IMG_HEIGHT = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic row_shift_rdy_i,
   input  logic win_ready_i,
   output logic accept_o,
   output logic win_valid_o,
   output logic stripe_done_o
);

   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int FW = $clog2(KERNEL + 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(KERNEL);

   generate
      if (IMG_HEIGHT < KERNEL) begin : g_bad_height
         $error("row_window_ctrl: IMG_HEIGHT must be >= KERNEL");
      end
   endgenerate

   win_state_t    state_q, state_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [FW-1:0] fill_cnt_q, fill_cnt_d;
   logic [FW-1:0] fill_inc;
   logic          win_valid_q, win_valid_d;
   logic          stripe_done_q, stripe_done_d;
   logic          accept;

   // A slice may be taken whenever the window slot is free or is being
   // consumed this same cycle, so a consume and a refill overlap.
   assign accept = row_shift_rdy_i && (!win_valid_q || win_ready_i);

   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      fill_cnt_d    = fill_cnt_q;
      win_valid_d   = win_valid_q;
      stripe_done_d = 1'b0;
      fill_inc      = (fill_cnt_q == FILL_FULL) ? FILL_FULL : fill_cnt_q + FW'(1);

      if (accept) begin
         fill_cnt_d = fill_inc;
         row_cnt_d  = row_cnt_q + RW'(1);
         case (state_q)
            FILL: begin
               // Any earlier valid window was consumed by this accept, so
               // the flag drops until the stripe's window is full again.
               if (fill_inc == FILL_FULL) begin
                  win_valid_d = 1'b1;
                  state_d     = SLIDE;
               end else begin
                  win_valid_d = 1'b0;
               end
            end
            SLIDE:   win_valid_d = 1'b1;
            default: state_d = FILL;
         endcase
         // Last row of the stripe: this window is still valid, but the
         // next stripe must refill from scratch.
         if (row_cnt_q == ROW_LAST) begin
            row_cnt_d     = '0;
            fill_cnt_d    = '0;
            state_d       = FILL;
            stripe_done_d = 1'b1;
         end
      end else if (win_valid_q && win_ready_i) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= FILL;
         row_cnt_q     <= '0;
         fill_cnt_q    <= '0;
         win_valid_q   <= 1'b0;
         stripe_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         fill_cnt_q    <= fill_cnt_d;
         win_valid_q   <= win_valid_d;
         stripe_done_q <= stripe_done_d;
      end
   end

   assign accept_o      = accept;
   assign win_valid_o   = win_valid_q;
   assign stripe_done_o = stripe_done_q;

endmodule : row_window_ctrl
`default_nettype wire

// File: rtl/row_window_buf.sv
`default_nettype none
// ============================================================================
//  Module   : row_window_buf
//  Purpose  : Pops KERNEL-wide row slices from the row shift register and
//             stacks the most recent KERNEL of them into a KERNEL x KERNEL
//             window; row 0 of the window is the oldest row. Windows never
//             span two image-height stripes.
//  Ports    : clock, reset (async, active-low)
//             row_shift_rdy / p_row_in / row_shift_up - upstream slice i/f
//             win_valid / win_ready / window          - downstream window i/f
//             stripe_done - one-cycle pulse after a stripe's last row
//             win_count, stall_cnt - only with ROW_WINDOW_BUF_STATS_EN
//  Options  : `define ROW_WINDOW_BUF_STATS_EN adds the handshake counter
//             win_count (wrapping) and the backpressure counter stall_cnt
//             (saturating).
//  Revision : 1.0  initial release
// ============================================================================
module row_window_buf
   import cnn_pkg::*;
#(
   parameter int KERNEL     = 3,
   parameter int IMG_HEIGHT = 5,
   parameter int PIXEL_W    = PIXEL_W_DEF
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         row_shift_rdy,
   input  logic [KERNEL*PIXEL_W-1:0]    p_row_in,
   output logic                         row_shift_up,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic [KERNEL*KERNEL*PIXEL_W-1:0] window,
   output logic                         stripe_done
`ifdef ROW_WINDOW_BUF_STATS_EN
   ,
   output logic [15:0]                  win_count,
   output logic [15:0]                  stall_cnt
`endif
);

   localparam int ROW_BITS = KERNEL * PIXEL_W;
   localparam int WIN_BITS = KERNEL * ROW_BITS;

   logic                accept;
   logic [WIN_BITS-1:0] window_q, window_d;

   row_window_ctrl #(
      .KERNEL     (KERNEL),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_ctrl (
      .clock           (clock),
      .reset           (reset),
      .row_shift_rdy_i (row_shift_rdy),
      .win_ready_i     (win_ready),
      .accept_o        (accept),
      .win_valid_o     (win_valid),
      .stripe_done_o   (stripe_done)
   );

   // Shift the window up one row and place the fresh slice at the bottom.
   always_comb begin
      window_d = window_q;
      if (accept) begin
         for (int r = 0; r < KERNEL - 1; r++) begin
            window_d[r*ROW_BITS +: ROW_BITS] = window_q[(r+1)*ROW_BITS +: ROW_BITS];
         end
         window_d[(KERNEL-1)*ROW_BITS +: ROW_BITS] = p_row_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

   assign row_shift_up = accept;
   assign window       = window_q;

`ifdef ROW_WINDOW_BUF_STATS_EN
   logic [15:0] win_count_q;
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         win_count_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (win_valid && win_ready) begin
            win_count_q <= win_count_q + 16'd1;
         end
         if (row_shift_rdy && win_valid && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign win_count = win_count_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule : row_window_buf
`default_nettype wire

// File: tb/tb_row_window_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_row_window_buf
//  Purpose  : Self-checking bench for row_window_buf (KERNEL=3,
//             IMG_HEIGHT=5). Directed vector table plus randomized traffic
//             compared against a row-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_row_window_buf;

   localparam int K  = 3;
   localparam int H  = 5;
   localparam int PW = 8;
   localparam int RB = K * PW;
   localparam int WB = K * RB;

   logic          clock = 1'b0;
   logic          reset;
   logic          row_shift_rdy;
   logic [RB-1:0] p_row_in;
   logic          row_shift_up;
   logic          win_valid;
   logic          win_ready;
   logic [WB-1:0] window;
   logic          stripe_done;
`ifdef ROW_WINDOW_BUF_STATS_EN
   logic [15:0]   win_count;
   logic [15:0]   stall_cnt;
`endif

   always #5 clock = ~clock;

   row_window_buf #(.KERNEL(K), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
      .clock         (clock),
      .reset         (reset),
      .row_shift_rdy (row_shift_rdy),
      .p_row_in      (p_row_in),
      .row_shift_up  (row_shift_up),
      .win_valid     (win_valid),
      .win_ready     (win_ready),
      .window        (window),
      .stripe_done   (stripe_done)
`ifdef ROW_WINDOW_BUF_STATS_EN
      ,
      .win_count     (win_count),
      .stall_cnt     (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The window is simply the last K rows ever captured (zeros before any
   // exist); a window is valid once K rows of the current stripe arrived.
   logic [RB-1:0] hist[$];
   int            m_pos;       // rows accepted in current stripe
   logic          m_valid;
   logic          m_done;
   logic          m_acc;
   int            m_wc;
   int            m_sc;

   function automatic logic [WB-1:0] model_window();
      logic [WB-1:0] w = '0;
      for (int r = 0; r < K; r++) begin
         int idx = hist.size() - K + r;
         if (idx >= 0) w[r*RB +: RB] = hist[idx];
      end
      return w;
   endfunction

   function automatic logic [RB-1:0] mk_row(input int k);
      logic [RB-1:0] v;
      for (int c = 0; c < K; c++) v[c*PW +: PW] = PW'(3*k + c);
      return v;
   endfunction

   function automatic logic [WB-1:0] mk_win(input int base);
      logic [WB-1:0] v;
      for (int i = 0; i < K*K; i++) v[i*PW +: PW] = PW'(base + i);
      return v;
   endfunction

   function automatic void model_reset();
      hist.delete();
      m_pos = 0; m_valid = 1'b0; m_done = 1'b0; m_acc = 1'b0;
      m_wc = 0; m_sc = 0;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".win_valid"},   win_valid,   m_valid);
      check({tag, ".stripe_done"}, stripe_done, m_done);
      check({tag, ".window"},      window,      model_window());
`ifdef ROW_WINDOW_BUF_STATS_EN
      check({tag, ".win_count"},   win_count,   16'(m_wc));
      check({tag, ".stall_cnt"},   stall_cnt,   16'(m_sc));
`endif
   endtask

   // One clock: drive inputs, check the combinational pop strobe, advance
   // the clock and the model, then check registered outputs.
   task automatic step(input logic rdy, input logic rw, input logic [RB-1:0] data, input string tag);
      row_shift_rdy = rdy;
      win_ready     = rw;
      p_row_in      = data;
      #1;
      m_acc = rdy && (!m_valid || rw);
      check({tag, ".row_shift_up"}, row_shift_up, m_acc);
      if (m_valid && rw) m_wc = (m_wc + 1) % 65536;
      if (rdy && m_valid && !rw && m_sc < 65535) m_sc++;
      m_done = 1'b0;
      if (m_acc) begin
         hist.push_back(data);
         if (hist.size() > K) void'(hist.pop_front());
         m_pos++;
         m_valid = (m_pos >= K);
         if (m_pos == H) begin
            m_pos  = 0;
            m_done = 1'b1;
         end
      end else if (m_valid && rw) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("reset.win_valid",   win_valid,   1'b0);
      check("reset.stripe_done", stripe_done, 1'b0);
      check("reset.window",      window,      '0);
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic rdy;
      logic rw;
      logic exp_up;
      logic exp_valid;
      logic exp_done;
      int   base;        // window byte i == base+i, or -1 for no check
   } vec_t;

   vec_t tbl[16];

   initial begin
      int kk;
      reset         = 1'b1;
      row_shift_rdy = 1'b0;
      win_ready     = 1'b0;
      p_row_in      = '0;
      model_reset();
      #3;
      do_reset();

      tbl[0]  = '{1, 1, 1, 0, 0, -1};
      tbl[1]  = '{1, 1, 1, 0, 0, -1};
      tbl[2]  = '{1, 1, 1, 1, 0,  0};
      tbl[3]  = '{1, 1, 1, 1, 0,  3};
      tbl[4]  = '{1, 0, 0, 1, 0,  3};
      tbl[5]  = '{1, 0, 0, 1, 0,  3};
      tbl[6]  = '{1, 0, 0, 1, 0,  3};
      tbl[7]  = '{1, 0, 0, 1, 0,  3};
      tbl[8]  = '{1, 1, 1, 1, 1,  6};
      tbl[9]  = '{1, 1, 1, 0, 0,  9};
      tbl[10] = '{1, 1, 1, 0, 0, 12};
      tbl[11] = '{1, 1, 1, 1, 0, 15};
      tbl[12] = '{0, 1, 0, 0, 0, 15};
      tbl[13] = '{0, 1, 0, 0, 0, 15};
      tbl[14] = '{1, 0, 1, 1, 0, 18};
      tbl[15] = '{1, 0, 0, 1, 0, 18};

      kk = 0;
      for (int i = 0; i < 16; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tbl[i].rdy, tbl[i].rw, mk_row(kk), tag);
         // table constants, independent of the model
         check({tag, ".tbl_valid"}, win_valid,   tbl[i].exp_valid);
         check({tag, ".tbl_done"},  stripe_done, tbl[i].exp_done);
         if (tbl[i].base >= 0) check({tag, ".tbl_window"}, window, mk_win(tbl[i].base));
         if (tbl[i].exp_up) kk++;
`ifdef ROW_WINDOW_BUF_STATS_EN
         if (i == 7) check("bp.stall_cnt", stall_cnt, 16'd4);
`endif
      end

      // Reset in the middle of a stripe: filling restarts from row 0.
      do_reset();
      kk = 100;
      step(1, 1, mk_row(kk), "rst_fill0"); kk++;
      check("rst_fill0.tbl_valid", win_valid, 1'b0);
      step(1, 1, mk_row(kk), "rst_fill1"); kk++;
      check("rst_fill1.tbl_valid", win_valid, 1'b0);
      step(1, 1, mk_row(kk), "rst_fill2"); kk++;
      check("rst_fill2.tbl_valid", win_valid, 1'b1);
      check("rst_fill2.tbl_window", window, mk_win(300));

      // Randomized traffic with one asynchronous reset mid-run.
      for (int n = 0; n < 3000; n++) begin
         logic rdy, rw;
         rdy = ($urandom_range(0, 3) != 0);
         rw  = ($urandom_range(0, 2) != 0);
         if (n == 1500) do_reset();
         step(rdy, rw, RB'($urandom), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_row_window_buf
`default_nettype wire

// File: doc/row_window_buf.md
Name: row_window_buf

Overview:
- Downstream consumer of the row shift register. It pops KERNEL-wide row slices and stacks the last KERNEL of them into a KERNEL x KERNEL pixel window for the convolution array.
- Drives the row shift register's shift_row_up strobe whenever a slice is ready and the window register can accept it.
- Tracks image-height stripes. At each stripe boundary it refills from scratch, so no window ever spans two stripes.

Parameters:
- KERNEL, 3, kernel edge; equals ROW_SHIFT of the upstream row shift register.
- IMG_HEIGHT, 5, rows per column stripe; must be >= KERNEL (elaboration error otherwise).
- PIXEL_W, 8, pixel width in bits.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- row_shift_rdy  in  1  upstream holds at least KERNEL pixels.
- p_row_in  in  KERNEL*PIXEL_W  upstream parallel slice; element c = p_row_in[c*PIXEL_W +: PIXEL_W].
- row_shift_up  out  1  pop strobe to upstream (combinational).
- win_valid  out  1  window holds a complete KERNEL x KERNEL window.
- win_ready  in  1  downstream accepts the window this cycle.
- window  out  KERNEL*KERNEL*PIXEL_W  element (r,c) = window[(r*KERNEL+c)*PIXEL_W +: PIXEL_W]; r=0 is the oldest row.
- stripe_done  out  1  one-cycle pulse after the last row of a stripe is accepted.

Behaviour:
- Reset (async, low): window=0, win_valid=0, stripe_done=0, row_cnt=0, fill_cnt=0, state=FILL.
- Accept condition:
  - accept = row_shift_rdy && (!win_valid || win_ready).
  - row_shift_up = accept, combinational, so there is no bubble.
  - On accept, upstream pops on the same edge and this block captures p_row_in on that edge.
- On accept (shift up):
  - row r <= row r+1 for r < KERNEL-1.
  - row KERNEL-1 <= p_row_in.
  - fill_cnt <= min(fill_cnt+1, KERNEL).
  - row_cnt <= row_cnt+1.
- State machine:
  - FILL: win_valid <= 1 on the accept that makes fill_cnt reach KERNEL; state moves to SLIDE.
  - SLIDE: every accept sets win_valid <= 1, a new window one row lower.
  - In both states, win_valid && win_ready with no accept clears win_valid.
- Stripe end:
  - Triggered by an accept with row_cnt == IMG_HEIGHT-1.
  - win_valid is still set per the rules above.
  - row_cnt <= 0, fill_cnt <= 0, state <= FILL.
  - stripe_done = 1 for the next cycle only.
  - Stale rows stay in the window register but are never flagged valid.
- Latency: one cycle from the accept edge to the new window appearing with win_valid.
- Backpressure: while win_valid=1 && win_ready=0, row_shift_up=0 and window, win_valid and counters hold.
- Simultaneous consume and accept: the new window replaces the old one and win_valid stays 1. Throughput is one window per cycle in SLIDE.
- Upstream empty (row_shift_rdy=0): no pop, state holds, win_valid clears only on consume.
- Reset mid-stripe: all state is discarded and filling restarts from row 0.
- row_cnt width: clog2(IMG_HEIGHT). fill_cnt width: clog2(KERNEL+1). No arithmetic on pixel data.

Optional Feature:
- Macro: ROW_WINDOW_BUF_STATS_EN.
- Defined:
  - Adds output win_count [15:0], reset 0.
  - Increments on each win_valid && win_ready and wraps at 0xFFFF -> 0.
  - Adds output stall_cnt [15:0], which increments each cycle row_shift_rdy && win_valid && !win_ready and saturates at 0xFFFF.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package cnn_pkg:
  - PIXEL_W default constant.
  - pixel_t typedef.
  - Window FSM state enum {FILL, SLIDE}.
- One sub-module, row_window_ctrl:
  - Owns the FSM, row_cnt, fill_cnt, accept and stripe_done.
  - The top level holds the window datapath and the optional stats counters.

Test Plan (KERNEL=3, IMG_HEIGHT=5, upstream model supplies row k as bytes {3k+2, 3k+1, 3k} high to low):
- Reset: hold reset low mid-run, then release -> all outputs 0, first valid window only after 3 new accepts.
- Fill: row_shift_rdy=1 and win_ready=1 continuously -> row_shift_up high every cycle; the edge after the 3rd accept gives win_valid=1 and window byte i = i for i = 0..8.
- Slide: next accept -> window bytes 3..11, win_valid stays 1 with no bubble.
- Backpressure: win_ready=0 for 4 cycles with row_shift_rdy=1 -> row_shift_up=0 and window unchanged (bytes 3..11); on win_ready=1 the pop resumes the same cycle.
- Stripe: 5th accept -> window bytes 6..14, stripe_done pulses one cycle. Accepts 6 and 7 give win_valid=0. Accept 8 gives window bytes 15..23.
- Starve: row_shift_rdy=0 after the window is consumed -> win_valid=0, row_shift_up=0, counters hold.
- With ROW_WINDOW_BUF_STATS_EN: win_count equals the number of handshakes and stall_cnt equals 4 after the backpressure scenario.
